// File: rtl/riscv_hwloop_sequencer.sv
// Hardware-loop sequencer: detects loop-end retirement, pulses the loop
// counter decrement and holds a jump request to fetch until it is accepted.
module riscv_hwloop_sequencer #(
  parameter int unsigned N_LOOPS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_i,
  input  logic                   pc_valid_i,
  input  logic [N_LOOPS*32-1:0]  hwlp_start_addr_i,
  input  logic [N_LOOPS*32-1:0]  hwlp_end_addr_i,
  input  logic [N_LOOPS*32-1:0]  hwlp_counter_i,
  input  logic                   jump_ack_i,
  output logic [N_LOOPS-1:0]     hwlp_dec_cnt_o,
  output logic                   jump_o,
  output logic [31:0]            jump_addr_o,
  output logic                   loop_exit_o,
  output logic                   busy_o
);

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                jump_q, jump_d;
  logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;
  logic                loop_exit_q, loop_exit_d;

  logic [N_LOOPS-1:0]  match;
  logic [N_LOOPS-1:0]  sel_oh;
  logic                any_match;
  logic [ADDR_W-1:0]   sel_start;
  logic [ADDR_W-1:0]   sel_cnt;

  // Per-loop end-address hit on a qualified retire of an active loop
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(N_LOOPS); i++) begin
      match[i] = pc_valid_i
               && (pc_i == hwlp_end_addr_i[ADDR_W*i +: ADDR_W])
               && (hwlp_counter_i[ADDR_W*i +: ADDR_W] != '0);
    end
  end

  // Priority select: scan outer to inner so the innermost hit wins
  always_comb begin
    any_match = 1'b0;
    sel_oh    = '0;
    sel_start = '0;
    sel_cnt   = '0;
    for (int i = int'(N_LOOPS) - 1; i >= 0; i--) begin
      if (match[i]) begin
        any_match = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_start = hwlp_start_addr_i[ADDR_W*i +: ADDR_W];
        sel_cnt   = hwlp_counter_i[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      jump_q      <= 1'b0;
      jump_addr_q <= '0;
      loop_exit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      jump_q      <= jump_d;
      jump_addr_q <= jump_addr_d;
      loop_exit_q <= loop_exit_d;
    end
  end

  // Next-state: start a jump on a non-final iteration, pulse exit on the last
  always_comb begin
    state_d     = state_q;
    jump_d      = jump_q;
    jump_addr_d = jump_addr_q;
    loop_exit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_match) begin
          if (sel_cnt > ADDR_W'(1)) begin
            jump_d      = 1'b1;
            jump_addr_d = sel_start;
            state_d     = PEND;
          end else begin
            loop_exit_d = 1'b1;
          end
        end
      end
      PEND: begin
        if (jump_ack_i) begin
          jump_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        jump_d  = 1'b0;
      end
    endcase
  end

  // Outputs: decrement only from IDLE, everything else straight from flops
  always_comb begin
    hwlp_dec_cnt_o = '0;
    if ((state_q == IDLE) && any_match) begin
      hwlp_dec_cnt_o = sel_oh;
    end
    jump_o      = jump_q;
    jump_addr_o = jump_addr_q;
    loop_exit_o = loop_exit_q;
    busy_o      = (state_q == PEND);
  end

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// Scoreboard bench for riscv_hwloop_sequencer (two loops).
module tb_riscv_hwloop_sequencer;

  localparam int unsigned N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     pc_i;
  logic            pc_valid_i;
  logic [N*32-1:0] hwlp_start_addr_i;
  logic [N*32-1:0] hwlp_end_addr_i;
  logic [N*32-1:0] hwlp_counter_i;
  logic            jump_ack_i;
  logic [N-1:0]    hwlp_dec_cnt_o;
  logic            jump_o;
  logic [31:0]     jump_addr_o;
  logic            loop_exit_o;
  logic            busy_o;

  logic [31:0] st [N];
  logic [31:0] en [N];
  logic [31:0] ct [N];

  typedef struct packed {
    logic [N-1:0] dec;
    logic         jump;
    logic [31:0]  addr;
    logic         chk_addr;
    logic         ex;
    logic         busy;
  } row_t;

  row_t sb_q[$];
  row_t obs_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    hwlp_start_addr_i = {st[1], st[0]};
    hwlp_end_addr_i   = {en[1], en[0]};
    hwlp_counter_i    = {ct[1], ct[0]};
  end

  riscv_hwloop_sequencer #(.N_LOOPS(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .pc_valid_i        (pc_valid_i),
    .hwlp_start_addr_i (hwlp_start_addr_i),
    .hwlp_end_addr_i   (hwlp_end_addr_i),
    .hwlp_counter_i    (hwlp_counter_i),
    .jump_ack_i        (jump_ack_i),
    .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
    .jump_o            (jump_o),
    .jump_addr_o       (jump_addr_o),
    .loop_exit_o       (loop_exit_o),
    .busy_o            (busy_o)
  );

  // Expected row: dec in this cycle, registered outputs after the coming edge
  function automatic row_t mk(input logic [N-1:0] dec, input logic jump,
                              input logic [31:0] addr, input logic ex, input logic busy);
    row_t r;
    r.dec = dec; r.jump = jump; r.addr = addr; r.chk_addr = jump; r.ex = ex; r.busy = busy;
    return r;
  endfunction

  function automatic row_t mk_rst();
    row_t r;
    r = '0;
    r.chk_addr = 1'b1;
    return r;
  endfunction

  // One clock of stimulus; pushes expectation and the matching observation
  task automatic cyc(input logic [31:0] pc, input logic v, input logic ack,
                     input logic r, input row_t e);
    row_t o;
    pc_i = pc; pc_valid_i = v; jump_ack_i = ack; rst = r;
    sb_q.push_back(e);
    #4;
    o.dec = hwlp_dec_cnt_o;
    @(posedge clk); #1;
    o.jump = jump_o; o.addr = jump_addr_o; o.chk_addr = e.chk_addr;
    o.ex = loop_exit_o; o.busy = busy_o;
    obs_q.push_back(o);
    pc_valid_i = 1'b0; jump_ack_i = 1'b0; rst = 1'b0;
  endtask

  task automatic set_loop(input int i, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] c);
    st[i] = s; en[i] = e; ct[i] = c;
  endtask

  task automatic test_reset();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h0, 32'h0, 32'h0);
    set_loop(1, 32'h0, 32'h0, 32'h0);
    cyc(32'h0, 1'b0, 1'b0, 1'b1, mk_rst());
    cyc(32'h0, 1'b0, 1'b0, 1'b1, mk_rst());
    cyc(32'h0, 1'b0, 1'b1, 1'b0, mk_rst());   // ack ignored in IDLE
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL reset row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_single_loop();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h100, 32'h10C, 32'd3);
    set_loop(1, 32'h500, 32'h50C, 32'd0);
    cyc(32'h10C, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h100, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    cyc(32'h10C, 1'b0, 1'b0, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL single_loop row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_loop_exit();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h100, 32'h10C, 32'd1);
    cyc(32'h10C, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b0, 32'h0, 1'b1, 1'b0));
    cyc(32'h0,   1'b0, 1'b0, 1'b0, mk(2'b00, 1'b0, 32'h0, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL loop_exit row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_nested();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h110, 32'h120, 32'd2);
    set_loop(1, 32'h100, 32'h140, 32'd5);
    cyc(32'h120, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h110, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    cyc(32'h140, 1'b1, 1'b0, 1'b0, mk(2'b10, 1'b1, 32'h100, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL nested row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_shared_end();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h1C0, 32'h200, 32'd4);
    set_loop(1, 32'h180, 32'h200, 32'd7);
    cyc(32'h200, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h1C0, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    // Outer loop alone on its final iteration at the shared end
    set_loop(0, 32'h1C0, 32'h200, 32'd0);
    set_loop(1, 32'h180, 32'h200, 32'd1);
    cyc(32'h200, 1'b1, 1'b0, 1'b0, mk(2'b10, 1'b0, 32'h0,   1'b1, 1'b0));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL shared_end row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h300, 32'h33C, 32'd9);
    set_loop(1, 32'h0, 32'h0, 32'd0);
    cyc(32'h33C, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h300, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++)
      cyc(32'h33C, 1'b1, 1'b0, 1'b0, mk(2'b00, 1'b1, 32'h300, 1'b0, 1'b1));
    // Match in the ack cycle is still ignored; next cycle is accepted
    cyc(32'h33C, 1'b1, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    cyc(32'h33C, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h300, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    // Max counter value counts as more iterations to go
    set_loop(0, 32'h300, 32'h33C, 32'hFFFF_FFFF);
    cyc(32'h33C, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h300, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b1, 1'b0, mk(2'b00, 1'b0, 32'h0,   1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL back_to_back row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  task automatic test_rst_pend();
    row_t e, o;
    int n = 0;
    set_loop(0, 32'h400, 32'h404, 32'd2);
    set_loop(1, 32'h0, 32'h0, 32'd0);
    cyc(32'h404, 1'b1, 1'b0, 1'b0, mk(2'b01, 1'b1, 32'h400, 1'b0, 1'b1));
    cyc(32'h0,   1'b0, 1'b0, 1'b1, mk_rst());
    cyc(32'h0,   1'b0, 1'b0, 1'b0, mk_rst());
    // Inactive loops never match
    set_loop(0, 32'h400, 32'h404, 32'd0);
    set_loop(1, 32'h480, 32'h404, 32'd0);
    cyc(32'h404, 1'b1, 1'b0, 1'b0, mk(2'b00, 1'b0, 32'h0, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.dec !== e.dec || o.jump !== e.jump || o.ex !== e.ex || o.busy !== e.busy ||
          (e.chk_addr && o.addr !== e.addr)) begin
        errors++;
        $display("FAIL rst_pend row %0d: got dec=%b jump=%b addr=%h exit=%b busy=%b, required dec=%b jump=%b addr=%h exit=%b busy=%b",
                 n, o.dec, o.jump, o.addr, o.ex, o.busy, e.dec, e.jump, e.addr, e.ex, e.busy);
      end
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; jump_ack_i = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      st[i] = '0; en[i] = '0; ct[i] = '0;
    end
    @(posedge clk); #1;
    test_reset();
    test_single_loop();
    test_loop_exit();
    test_nested();
    test_shared_end();
    test_back_to_back();
    test_rst_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_sequencer.md
# riscv_hwloop_sequencer

Sequences up to N_LOOPS hardware loops for the RI5CY core. The block sits between the hardware-loop register file and the fetch stage. It compares the address of each instruction leaving ID against the programmed loop end addresses, issues a decrement pulse to the loop register file, and raises a held jump request to fetch until fetch acknowledges it. Inner loops (lower index) take priority over outer loops.

## Interface
Parameters:
- N_LOOPS, 2, number of loop register sets (1..4); index 0 is the innermost loop.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous and active-high.
- pc_i  in  32  address of the instruction leaving ID this cycle.
- pc_valid_i  in  1  instruction at pc_i leaves ID this cycle; a qualified retire.
- hwlp_start_addr_i  in  N_LOOPS*32  loop start addresses; loop i occupies bits [32i+31:32i].
- hwlp_end_addr_i  in  N_LOOPS*32  loop end addresses, same packing.
- hwlp_counter_i  in  N_LOOPS*32  current loop counters, same packing; 0 means the loop is inactive.
- jump_ack_i  in  1  fetch has accepted the jump target.
- hwlp_dec_cnt_o  out  N_LOOPS  one-hot decrement to the loop register file; combinational.
- jump_o  out  1  jump request to fetch; registered and held until acknowledged.
- jump_addr_o  out  32  jump target; registered, stable while jump_o is high.
- loop_exit_o  out  1  registered one-cycle pulse marking a final-iteration fall-through.
- busy_o  out  1  high while in state PEND.

## Operation
- match[i] = pc_valid_i & (pc_i == end_i) & (counter_i != 0), where end_i and counter_i are the 32-bit fields for loop i.
- sel = the lowest index with match[i] set. Only sel is serviced. If several loops share an end address, only the lowest index is serviced; this is the intended behaviour.
- The state machine has two states, IDLE and PEND.
- IDLE with a match:
  - hwlp_dec_cnt_o[sel] = 1 in the same cycle.
  - If counter_sel > 1: at the next edge, jump_o <= 1, jump_addr_o <= start_sel, and the state goes to PEND.
  - If counter_sel == 1: no jump. At the next edge, loop_exit_o <= 1 and the state stays IDLE.
- IDLE without a match: all outputs inactive.
- PEND:
  - jump_o and jump_addr_o hold their values.
  - Matches are ignored and hwlp_dec_cnt_o = 0, because the instruction stream is being redirected.
  - When jump_ack_i = 1: at the next edge, jump_o <= 0 and the state goes to IDLE.
- jump_ack_i is ignored in IDLE.
- Counter comparisons use the pre-decrement value. The register file applies the decrement at the end of the same cycle.
- hwlp_dec_cnt_o is always zero or one-hot. It is never asserted while pc_valid_i = 0.
- Counter values are compared as unsigned 32-bit values. 0xFFFF_FFFF counts as > 1. There is no wrap handling; the register file owns the arithmetic.
- Configuration writes to the register file are not visible to this block except through its inputs. A jump already in PEND completes with its latched target.

## Timing
- Reset values: jump_o = 0, jump_addr_o = 0, loop_exit_o = 0, busy_o = 0, hwlp_dec_cnt_o = 0, state = IDLE.
- Latency from decision cycle T:
  - hwlp_dec_cnt_o is asserted in cycle T.
  - jump_o and busy_o are high from T+1.
  - loop_exit_o is high in T+1 only.
- An ack in cycle T+1 (the first cycle jump_o is high) gives jump_o = 0 at T+2. A new match is accepted from T+2.
- Matches presented in an ack cycle are ignored, because that cycle is still PEND.
- With no ack, jump_o is held indefinitely and jump_addr_o stays stable.
- When rst is asserted in any state, all outputs clear at the next edge, including a pending jump, which is dropped.
- There are no combinational paths from jump_ack_i to any output.

## Test plan
- Single loop, start = 0x100, end = 0x10C, counter = 3, pc_valid at 0x10C. Required response:
  - dec = 01 in cycle T.
  - jump_o = 1 with addr 0x100 at T+1.
  - ack at T+1 gives jump_o = 0 at T+2.
- Same loop with counter = 1 at 0x10C. Required response: dec = 01, no jump_o, loop_exit_o pulse at T+1, busy_o stays 0.
- Nested loops:
  - Setup: L0 end = 0x120 counter = 2; L1 end = 0x140 counter = 5.
  - pc 0x120 -> dec = 01 and jump to start0.
  - pc 0x140 -> dec = 10 and jump to start1.
- Shared end address 0x200, L0 counter = 4, L1 counter = 7. Required response: dec = 01 only, jump to start0.
- Ack withheld for 5 cycles while pc_valid at end0 is presented every cycle. Required response:
  - jump_o is held with a stable address.
  - dec stays 0 throughout.
  - Release follows the ack.
- rst asserted while in PEND. Required response:
  - jump_o = 0 and busy_o = 0 at the next edge.
  - Inactive loops (counter = 0) with a pc match produce no dec and no jump.
